// File: rtl/mem_if_pkg.sv
// Shared definitions for the LSU memory master: access-size codes, FSM
// state encoding and the byte-lane helper functions.
package mem_if_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 is reserved and behaves as a word

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT_R = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Byte enables for an access of the given size at byte offset off.
   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // True when the offset is not a multiple of the access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   // Offset with the low bits that break natural alignment cleared.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] aoff;
      case (size)
         SZ_BYTE: aoff = off;
         SZ_HALF: aoff = {off[1], 1'b0};
         default: aoff = 2'b00;
      endcase
      return aoff;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// CPU-side request/response and memory-side handshake signals of the LSU.
// master: the LSU itself; slave: the environment (pipeline + data memory).
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_pc;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc
   );

   modport slave (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: byte enables and lane replication for the
// outgoing store, lane extraction and sign/zero extension for the returned load.
module lsu_lane_align
   import mem_if_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_sign,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);
   logic [31:0] lane_s;

   // Store side: enables from size/offset, data copied into every lane it may land in
   always_comb begin
      st_be = be_gen(st_size, st_off);
      case (st_size)
         SZ_BYTE: st_wdata_rep = {4{st_wdata[7:0]}};
         SZ_HALF: st_wdata_rep = {2{st_wdata[15:0]}};
         default: st_wdata_rep = st_wdata;
      endcase
   end

   // Load side: shift the addressed lane down, then extend to 32 bits
   always_comb begin
      lane_s = ld_rdata >> {ld_off, 3'b000};
      case (ld_size)
         SZ_BYTE: ld_data = {{24{ld_sign & lane_s[7]}}, lane_s[7:0]};
         SZ_HALF: ld_data = {{16{ld_sign & lane_s[15]}}, lane_s[15:0]};
         default: ld_data = lane_s;
      endcase
   end
endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and word-addressed data memory.
// One access in flight; request/grant/rvalid handshake with a timeout bound.
// Build option ALIGN_CHECK_EN: misaligned half/word accesses complete at once
// with rsp_err and never reach memory; without it the offending low address
// bits are cleared and the access proceeds.
module lsu_mem_master
   import mem_if_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input logic              clk,
   input logic              reset,
   lsu_mem_master_if.master bus
);
   // Last counter value that still counts as in time; at or beyond it the access aborts.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_e             state_r, state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               we_r, sign_r;
   logic [1:0]         size_r, off_r;
   logic               accept_s, timeout_s, misalign_s;
   logic [1:0]         eff_off_s;
   logic [3:0]         st_be_s;
   logic [31:0]        st_wdata_s, ld_data_s;
   logic               rsp_valid_r, rsp_err_r, mem_req_r, mem_we_r;
   logic [31:0]        rsp_rdata_r, mem_addr_r, mem_wdata_r, mem_pc_r;
   logic [3:0]         mem_be_r;
   logic               rsp_err_nxt_s;
   logic [31:0]        rsp_rdata_nxt_s;

   assign accept_s  = bus.req_valid && (state_r == IDLE);
   assign timeout_s = (cnt_r >= CNT_LAST);

   // Offset normalisation and misalignment detection for the incoming request
   always_comb begin
`ifdef ALIGN_CHECK_EN
      eff_off_s  = bus.req_addr[1:0];
      misalign_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
      eff_off_s  = align_off(bus.req_size, bus.req_addr[1:0]);
      misalign_s = 1'b0;
`endif
   end

   lsu_lane_align u_lane_align (
      .st_size      (bus.req_size),
      .st_off       (eff_off_s),
      .st_wdata     (bus.req_wdata),
      .st_be        (st_be_s),
      .st_wdata_rep (st_wdata_s),
      .ld_size      (size_r),
      .ld_off       (off_r),
      .ld_sign      (sign_r),
      .ld_rdata     (bus.mem_rdata),
      .ld_data      (ld_data_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // FSM next state; a handshake on the timeout edge takes priority over the abort
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = misalign_s ? RESP : ISSUE;
            else          state_nxt_s = IDLE;
         end
         ISSUE: begin
            if (bus.mem_gnt)    state_nxt_s = we_r ? RESP : WAIT_R;
            else if (timeout_s) state_nxt_s = RESP;
            else                state_nxt_s = ISSUE;
         end
         WAIT_R: begin
            if (bus.mem_rvalid)  state_nxt_s = RESP;
            else if (timeout_s)  state_nxt_s = RESP;
            else                 state_nxt_s = WAIT_R;
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: next-cycle error flag and load data for the response registers
   always_comb begin
      rsp_err_nxt_s   = 1'b0;
      rsp_rdata_nxt_s = 32'd0;
      case (state_r)
         IDLE: begin
            if (accept_s && misalign_s) rsp_err_nxt_s = 1'b1;
            else                        rsp_err_nxt_s = 1'b0;
         end
         ISSUE: begin
            if (!bus.mem_gnt && timeout_s) rsp_err_nxt_s = 1'b1;
            else                           rsp_err_nxt_s = 1'b0;
         end
         WAIT_R: begin
            if (bus.mem_rvalid) begin
               rsp_rdata_nxt_s = ld_data_s;
            end else if (timeout_s) begin
               rsp_err_nxt_s = 1'b1;
            end else begin
               rsp_err_nxt_s = 1'b0;
            end
         end
         default: rsp_err_nxt_s = 1'b0;
      endcase
   end

   // Request capture on accept and timeout counting while the access is outstanding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_r        <= 1'b0;
         sign_r      <= 1'b0;
         size_r      <= 2'd0;
         off_r       <= 2'd0;
         cnt_r       <= '0;
         mem_we_r    <= 1'b0;
         mem_be_r    <= 4'd0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         mem_pc_r    <= 32'd0;
      end else if (accept_s) begin
         we_r        <= bus.req_we;
         sign_r      <= bus.req_sign;
         size_r      <= bus.req_size;
         off_r       <= eff_off_s;
         cnt_r       <= '0;
         mem_we_r    <= bus.req_we;
         mem_be_r    <= st_be_s;
         mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
         mem_wdata_r <= st_wdata_s;
         mem_pc_r    <= bus.req_pc;
      end else if ((state_r == ISSUE) || (state_r == WAIT_R)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Registered response pulse and memory request line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 32'd0;
         mem_req_r   <= 1'b0;
      end else begin
         rsp_valid_r <= (state_nxt_s == RESP);
         rsp_err_r   <= rsp_err_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         mem_req_r   <= (state_nxt_s == ISSUE);
      end
   end

   assign bus.req_ready = (state_r == IDLE);
   assign bus.stall     = (state_r != IDLE);
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_pc    = mem_pc_r;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases plus randomized
// accesses compared against a byte-level reference model.
module tb_lsu_mem_master;
   localparam int TO = 255;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [3:0]  last_be;
   logic [31:0] last_wd, last_addr, last_rd;
   logic        last_err;
   int          last_lat, last_reqcnt;

   lsu_mem_master_if bus_if();

   lsu_mem_master #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   // One access: reference expectations from byte-lane rules, then cycle-by-cycle drive/observe.
   task automatic run_access(input bit we, input logic [1:0] size, input bit sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] pc, input logic [31:0] rdata,
                             input int gnt_dly, input int rv_dly, input bit collide);
      int nb, off, eoff, gnt_n, rv_n, t, exp_lat, exp_reqcnt, req_cnt, lat;
      bit abort, exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_rd, exp_addr;
      longint v;
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off = int'(addr[1:0]);
`ifdef ALIGN_CHECK_EN
      abort = ((off % nb) != 0);
      eoff  = off;
`else
      abort = 1'b0;
      eoff  = off - (off % nb);
`endif
      exp_addr = addr & 32'hFFFF_FFFC;
      exp_be   = 4'd0;
      exp_wd   = 32'd0;
      for (int i = 0; i < 4; i++) begin
         exp_be[i]         = (i >= eoff) && (i < eoff + nb);
         exp_wd[8*i +: 8]  = wdata[8*(i % nb) +: 8];
      end
      v = 0;
      if (!abort) begin
         for (int k = 0; k < nb; k++) v = v + (longint'(rdata[8*(eoff+k) +: 8]) << (8*k));
         if (sign && nb < 4 && v >= (longint'(1) << (8*nb-1))) v = v - (longint'(1) << (8*nb));
      end
      exp_rd  = v[31:0];
      gnt_n   = gnt_dly + 1;
      rv_n    = gnt_n + 1 + rv_dly;
      exp_err = 1'b0;
      if (abort) begin
         exp_lat = 1; exp_err = 1'b1; exp_reqcnt = 0;
      end else if (gnt_n > TO) begin
         exp_lat = TO + 1; exp_err = 1'b1; exp_reqcnt = TO;
      end else begin
         exp_reqcnt = gnt_n;
         if (we) exp_lat = gnt_n + 1;
         else begin
            t = (gnt_n + 1 > TO) ? gnt_n + 1 : TO;
            if (rv_n <= t) exp_lat = rv_n + 1;
            else begin exp_lat = t + 1; exp_err = 1'b1; end
         end
      end
      if (we || exp_err) exp_rd = 32'd0;

      @(negedge clk);
      chk("ready_idle", 32'(bus_if.req_ready), 32'd1);
      bus_if.req_valid = 1'b1;  bus_if.req_we    = we;    bus_if.req_size = size;
      bus_if.req_sign  = sign;  bus_if.req_addr  = addr;  bus_if.req_wdata = wdata;
      bus_if.req_pc    = pc;
      lat = -1; req_cnt = 0;
      for (int n = 1; n <= TO + 8; n++) begin
         @(negedge clk);
         if (bus_if.mem_req) req_cnt++;
         if (n == 1 && !abort) begin
            chk("issue_req",  32'(bus_if.mem_req),   32'd1);
            chk("mem_we",     32'(bus_if.mem_we),    32'(we));
            chk("mem_be",     32'(bus_if.mem_be),    32'(exp_be));
            chk("mem_addr",   bus_if.mem_addr,       exp_addr);
            chk("mem_wdata",  bus_if.mem_wdata,      exp_wd);
            chk("mem_pc",     bus_if.mem_pc,         pc);
            chk("stall_busy", 32'(bus_if.stall),     32'd1);
            chk("ready_busy", 32'(bus_if.req_ready), 32'd0);
            last_be = bus_if.mem_be; last_wd = bus_if.mem_wdata; last_addr = bus_if.mem_addr;
         end
         if (bus_if.rsp_valid) begin
            lat = n; last_err = bus_if.rsp_err; last_rd = bus_if.rsp_rdata;
            break;
         end
         bus_if.req_valid  = 1'($urandom_range(0, 1));
         bus_if.req_we     = 1'($urandom_range(0, 1));
         bus_if.req_size   = 2'($urandom_range(0, 3));
         bus_if.req_addr   = $urandom;
         bus_if.req_wdata  = $urandom;
         bus_if.req_pc     = $urandom;
         bus_if.mem_gnt    = (n == gnt_n);
         bus_if.mem_rvalid = (!we && n == rv_n) || (collide && n == gnt_n);
         bus_if.mem_rdata  = (n == rv_n) ? rdata : $urandom;
      end
      bus_if.req_valid = 1'b0; bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
      last_lat = lat; last_reqcnt = req_cnt;
      chk("latency",   32'(lat),     32'(exp_lat));
      chk("rsp_err",   32'(last_err), 32'(exp_err));
      chk("rsp_rdata", last_rd,      exp_rd);
      chk("req_cycles", 32'(req_cnt), 32'(exp_reqcnt));
      @(negedge clk);
      chk("rsp_pulse",  32'(bus_if.rsp_valid), 32'd0);
      chk("stall_drop", 32'(bus_if.stall),     32'd0);
      chk("ready_back", 32'(bus_if.req_ready), 32'd1);
      chk("req_low",    32'(bus_if.mem_req),   32'd0);
   endtask

   // Reset asserted mid-access (ISSUE or WAIT_R); nothing must complete.
   task automatic reset_mid(input bit in_wait);
      bit seen;
      @(negedge clk);
      bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_size = 2'd2;
      bus_if.req_sign = 1'b0;  bus_if.req_addr = 32'h0000_0100;
      @(negedge clk);
      bus_if.req_valid = 1'b0; bus_if.mem_gnt = in_wait;
      @(negedge clk);
      bus_if.mem_gnt = 1'b0;
      chk("rm_req_before",   32'(bus_if.mem_req), in_wait ? 32'd0 : 32'd1);
      chk("rm_stall_before", 32'(bus_if.stall),   32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rm_req_async",   32'(bus_if.mem_req), 32'd0);
      chk("rm_stall_async", 32'(bus_if.stall),   32'd0);
      bus_if.mem_rvalid = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus_if.rsp_valid) seen = 1'b1;
      end
      bus_if.mem_rvalid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      if (bus_if.rsp_valid) seen = 1'b1;
      chk("rm_no_rsp", 32'(seen), 32'd0);
      chk("rm_ready",  32'(bus_if.req_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'd0;
      bus_if.req_sign = 1'b0;  bus_if.req_addr = 32'd0; bus_if.req_wdata = 32'd0;
      bus_if.req_pc = 32'd0;   bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("rst_rsp_err",   32'(bus_if.rsp_err),   32'd0);
      chk("rst_rsp_rdata", bus_if.rsp_rdata,      32'd0);
      chk("rst_mem_req",   32'(bus_if.mem_req),   32'd0);
      chk("rst_mem_be",    32'(bus_if.mem_be),    32'd0);
      chk("rst_mem_addr",  bus_if.mem_addr,       32'd0);
      chk("rst_stall",     32'(bus_if.stall),     32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus_if.req_ready), 32'd1);

      // sb with zero-wait grant
      run_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 32'h1000, 32'd0, 0, 0, 1'b0);
      chk("sb_be",   32'(last_be), 32'h8);
      chk("sb_wd",   last_wd,      32'hA5A5_A5A5);
      chk("sb_addr", last_addr,    32'h10);
      chk("sb_lat",  32'(last_lat), 32'd2);
      // lh / lhu from the upper half
      run_access(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 32'h1004, 32'h8001_1234, 0, 0, 1'b0);
      chk("lh_rd",  last_rd, 32'hFFFF_8001);
      chk("lh_lat", 32'(last_lat), 32'd3);
      run_access(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 32'h1008, 32'h8001_1234, 0, 0, 1'b0);
      chk("lhu_rd", last_rd, 32'h0000_8001);
      // lb with grant delayed 5 cycles
      run_access(1'b0, 2'd0, 1'b1, 32'h01, 32'd0, 32'h100C, 32'h0000_7F00, 5, 0, 1'b0);
      chk("lb_reqcnt", 32'(last_reqcnt), 32'd6);
      chk("lb_rd",     last_rd,          32'h0000_007F);
      // lw never granted
      run_access(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 32'h1010, 32'h1234_5678, 1000, 0, 1'b0);
      chk("to_err", 32'(last_err), 32'd1);
      chk("to_rd",  last_rd,       32'd0);
      // grant / rvalid exactly on the timeout edges: handshake wins
      run_access(1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h1014, 32'd0, TO - 1, 0, 1'b0);
      chk("to_edge_st_err", 32'(last_err), 32'd0);
      run_access(1'b0, 2'd2, 1'b0, 32'h48, 32'd0, 32'h1018, 32'hDEAD_BEEF, TO - 1, 0, 1'b0);
      chk("to_edge_ld_rd", last_rd, 32'hDEAD_BEEF);
      run_access(1'b0, 2'd3, 1'b0, 32'h4C, 32'd0, 32'h101C, 32'h0BAD_F00D, 2, 300, 1'b0);
      // misaligned sw
      run_access(1'b1, 2'd2, 1'b0, 32'h06, 32'h1122_3344, 32'h1020, 32'd0, 0, 0, 1'b0);
`ifdef ALIGN_CHECK_EN
      chk("sw_mis_err",    32'(last_err),    32'd1);
      chk("sw_mis_reqcnt", 32'(last_reqcnt), 32'd0);
`else
      chk("sw_mis_addr", last_addr,    32'h04);
      chk("sw_mis_be",   32'(last_be), 32'hF);
`endif
      // gnt and rvalid together in ISSUE: rvalid ignored
      run_access(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 32'h1024, 32'h5555_AAAA, 0, 2, 1'b1);

      reset_mid(1'b0);
      run_access(1'b0, 2'd0, 1'b1, 32'h83, 32'd0, 32'h1028, 32'h9000_0000, 1, 1, 1'b0);
      reset_mid(1'b1);
      run_access(1'b1, 2'd1, 1'b0, 32'h86, 32'h0000_BEEF, 32'h102C, 32'd0, 0, 0, 1'b0);

      repeat (60) begin
         run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
